// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Issuing side of a combinational ALU. Accepts instruction
//                words over a valid/ready handshake, fetches two operands
//                from an internal register file, drives the ALU for one
//                cycle, writes the result back, keeps a sticky status-flag
//                register and returns the result over a second valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           clock, rising edge
//    rst           asynchronous active-high reset
//    instr_valid   instruction word present
//    instr_ready   sequencer can accept an instruction (IDLE only)
//    instr         {op[15:12], rd[11:9], ra[8:6], rb[5:3], unused[2:0]}
//    imm_data      immediate for LOAD, sampled together with instr
//    alu_a/alu_b   ALU operands (registered, stable during EXEC)
//    alu_opcode    ALU opcode (registered)
//    alu_out       ALU result (combinational from alu_a/alu_b/alu_opcode)
//    alu_flags     ALU flags {overflow, negative, zero}
//    result_valid  result available
//    result_ready  consumer takes the result
//    result_data   result value
//    result_flags  flags associated with the result
//    status_flags  sticky flags of the last flag-updating instruction
// ============================================================================
module alu_sequencer #(
    parameter int BW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    input  logic [BW-1:0] imm_data,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [BW-1:0] result_data,
    output logic [2:0]    result_flags,
    output logic [2:0]    status_flags
);

    // Register index width; the instruction fields are 3 bits wide, only
    // the low AW bits address the register file.
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] c_OP_LOAD   = 4'd8;
    localparam logic [3:0] c_ALU_PASSA = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [BW-1:0] r_rf [NREG];

    logic          r_instr_ready;
    logic          r_result_valid;
    logic [BW-1:0] r_alu_a;
    logic [BW-1:0] r_alu_b;
    logic [3:0]    r_alu_opcode;
    logic [BW-1:0] r_result_data;
    logic [2:0]    r_result_flags;
    logic [2:0]    r_status_flags;

    // Instruction field decode
    logic [3:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_ra;
    logic [AW-1:0] w_rb;
    logic          w_is_load;
    logic          w_is_nop;
    logic          w_writes;

    assign w_op      = instr[15:12];
    assign w_rd      = instr[9 +: AW];
    assign w_ra      = instr[6 +: AW];
    assign w_rb      = instr[3 +: AW];
    assign w_is_load = (w_op == c_OP_LOAD);
    assign w_is_nop  = (w_op > c_OP_LOAD);

    // Ops 0..8 (ALU ops and LOAD) write back and update status; 9..15 are NOPs.
    assign w_writes  = (r_op <= c_OP_LOAD);

    // Reserved bits and register-field bits above AW carry no meaning.
    logic w_unused_bits;
    assign w_unused_bits = ^{instr[2:0], instr[11:9], instr[8:6], instr[5:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_op           <= '0;
            r_rd           <= '0;
            r_instr_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_opcode   <= '0;
            r_result_data  <= '0;
            r_result_flags <= '0;
            r_status_flags <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op          <= w_op;
                        r_rd          <= w_rd;
                        r_instr_ready <= 1'b0;
                        r_state       <= ST_EXEC;
                        if (w_is_load) begin
                            // LOAD routes the immediate through the ALU as
                            // pass-A so flags come from the ALU as usual.
                            r_alu_a      <= imm_data;
                            r_alu_b      <= '0;
                            r_alu_opcode <= c_ALU_PASSA;
                        end else if (w_is_nop) begin
                            r_alu_a      <= '0;
                            r_alu_b      <= '0;
                            r_alu_opcode <= '0;
                        end else begin
                            r_alu_a      <= r_rf[w_ra];
                            r_alu_b      <= r_rf[w_rb];
                            r_alu_opcode <= w_op;
                        end
                    end
                end

                ST_EXEC: begin
                    // Operands were stable for the whole cycle; the ALU
                    // output is sampled at its end.
                    if (w_writes) begin
                        r_rf[r_rd]     <= alu_out;
                        r_status_flags <= alu_flags;
                        r_result_flags <= alu_flags;
                        r_result_data  <= alu_out;
                    end else begin
                        r_result_data  <= '0;
                        r_result_flags <= r_status_flags;
                    end
                    r_result_valid <= 1'b1;
                    r_state        <= ST_RESP;
                end

                ST_RESP: begin
                    // instr_ready stays low here, so a waiting instruction is
                    // only taken after the return to IDLE.
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_instr_ready  <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_instr_ready  <= 1'b1;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready  = r_instr_ready;
    assign result_valid = r_result_valid;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_opcode;
    assign result_data  = r_result_data;
    assign result_flags = r_result_flags;
    assign status_flags = r_status_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer with a
//                combinational ALU stand-in and a result scoreboard.
//                ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC,
//                6 PASS A, 7 NOT A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int BW = 16;

    logic          clk;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [BW-1:0] imm_data;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic [3:0]    alu_opcode;
    logic [BW-1:0] alu_out;
    logic [2:0]    alu_flags;
    logic          result_valid;
    logic          result_ready;
    logic [BW-1:0] result_data;
    logic [2:0]    result_flags;
    logic [2:0]    status_flags;

    alu_sequencer #(.BW(BW), .NREG(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .imm_data     (imm_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .result_flags (result_flags),
        .status_flags (status_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU reference: returns {overflow, negative, zero, result}
    function automatic logic [BW+2:0] alu_fn(input logic [BW-1:0] a,
                                             input logic [BW-1:0] b,
                                             input logic [3:0] op);
        logic [BW-1:0] r;
        logic          v;
        v = 1'b0;
        case (op)
            4'd0: begin r = a + b; v = (a[BW-1] == b[BW-1]) && (r[BW-1] != a[BW-1]); end
            4'd1: begin r = a - b; v = (a[BW-1] != b[BW-1]) && (r[BW-1] != a[BW-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a + 1'b1; v = (a == {1'b0, {(BW-1){1'b1}}}); end
            4'd6: r = a;
            4'd7: r = ~a;
            default: r = '0;
        endcase
        return {v, r[BW-1], (r == '0), r};
    endfunction

    always_comb begin
        logic [BW+2:0] t;
        t         = alu_fn(alu_a, alu_b, alu_opcode);
        alu_out   = t[BW-1:0];
        alu_flags = t[BW+2:BW];
    end

    typedef struct packed {
        logic [BW-1:0] data;
        logic [2:0]    flags;
    } sb_entry_t;

    sb_entry_t     sb[$];
    logic [BW-1:0] m_rf [8];
    logic [2:0]    m_status;
    logic [BW-1:0] exp_a;
    logic [BW-1:0] exp_b;
    logic [3:0]    exp_opc;
    logic [BW-1:0] obs_data;
    logic [2:0]    obs_flags;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb);
        return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
    endfunction

    // Sequencer reference: operands, write-back and expected response.
    task automatic model_issue(input int op, input int rd, input int ra, input int rb,
                               input logic [BW-1:0] imm);
        logic [BW+2:0] t;
        if (op == 8) begin
            exp_a = imm; exp_b = '0; exp_opc = 4'd6;
        end else if (op > 8) begin
            exp_a = '0; exp_b = '0; exp_opc = 4'd0;
        end else begin
            exp_a = m_rf[ra]; exp_b = m_rf[rb]; exp_opc = op[3:0];
        end
        t = alu_fn(exp_a, exp_b, exp_opc);
        if (op <= 8) begin
            m_rf[rd] = t[BW-1:0];
            m_status = t[BW+2:BW];
            sb.push_back('{data: t[BW-1:0], flags: t[BW+2:BW]});
        end else begin
            sb.push_back('{data: '0, flags: m_status});
        end
    endtask

    task automatic issue(input int op, input int rd, input int ra, input int rb,
                         input logic [BW-1:0] imm);
        int cyc;
        cyc = 0;
        while (!instr_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("issue_ready_timeout", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = mk(op, rd, ra, rb);
        imm_data    = imm;
        model_issue(op, rd, ra, rb, imm);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_opcode", alu_opcode, exp_opc);
        check("ready_low_in_exec", instr_ready, 0);
    endtask

    task automatic wait_result();
        int cyc;
        cyc = 0;
        while (!result_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("result_latency", cyc, 1);
    endtask

    task automatic take(input int hold);
        sb_entry_t e;
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result_data", result_data, e.data);
            check("result_flags", result_flags, e.flags);
        end
        obs_data  = result_data;
        obs_flags = result_flags;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", result_valid, 1);
            check("hold_data", result_data, obs_data);
            check("hold_flags", result_flags, obs_flags);
            check("hold_instr_ready", instr_ready, 0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("valid_drop", result_valid, 0);
        check("ready_back", instr_ready, 1);
    endtask

    task automatic collect(input int hold);
        wait_result();
        take(hold);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        imm_data     = '0;
        result_ready = 1'b0;
        m_status     = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_status", status_flags, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_result_data", result_data, 0);
        check("rst_result_flags", result_flags, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // result_ready high with nothing pending is ignored
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("idle_ready_ignored", result_valid, 0);

        // LOAD / ADD overflow into sign bit
        issue(8, 1, 0, 0, 16'h7FFF); collect(0);
        issue(8, 2, 0, 0, 16'h0001); collect(0);
        issue(0, 3, 1, 2, 16'h0000); wait_result();
        check("add_data_const", result_data, 16'h8000);
        check("add_flags_const", result_flags, 3'b110);
        check("add_status_const", status_flags, 3'b110);
        take(0);
        issue(6, 7, 3, 0, 16'h0000);
        check("rf3_readback", alu_a, 16'h8000);
        collect(0);

        // SUB to zero, then NOP keeps status
        issue(8, 4, 0, 0, 16'h0005); collect(0);
        issue(1, 5, 4, 4, 16'h0000); wait_result();
        check("sub_data_const", result_data, 16'h0000);
        check("sub_flags_const", result_flags, 3'b001);
        take(0);
        issue(9, 6, 1, 2, 16'hABCD); wait_result();
        check("nop_data_const", result_data, 16'h0000);
        check("nop_flags_const", result_flags, 3'b001);
        check("nop_status_const", status_flags, 3'b001);
        take(0);

        // Back-to-back dependent INC through wraparound
        issue(8, 1, 0, 0, 16'hFFFE); collect(0);
        issue(5, 1, 1, 0, 16'h0000); wait_result();
        check("inc1_data_const", result_data, 16'hFFFF);
        check("inc1_flags_const", result_flags, 3'b010);
        take(0);
        issue(5, 1, 1, 0, 16'h0000); wait_result();
        check("inc2_data_const", result_data, 16'h0000);
        check("inc2_flags_const", result_flags, 3'b001);
        take(0);

        // Extra ALU ops, ra == rb == rd, and a 5-cycle consumer stall
        issue(4, 4, 4, 4, 16'h0000); collect(0);
        issue(8, 2, 0, 0, 16'h0F0F); collect(0);
        issue(7, 3, 2, 0, 16'h0000); collect(5);
        issue(3, 3, 3, 2, 16'h0000); collect(0);

        // Reset during EXEC aborts the instruction
        issue(8, 1, 0, 0, 16'h1111); collect(0);
        issue(0, 6, 1, 2, 16'h0000);
        rst = 1'b1;
        #1;
        check("abort_valid", result_valid, 0);
        check("abort_instr_ready", instr_ready, 1);
        check("abort_status", status_flags, 0);
        sb.delete();
        m_status = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_no_result", result_valid, 0);
        issue(6, 7, 6, 0, 16'h0000);
        check("rf6_after_abort", alu_a, 16'h0000);
        collect(0);

        // instr_valid while in RESP: accepted only after IDLE, exactly once
        issue(8, 2, 0, 0, 16'h1234);
        wait_result();
        instr_valid = 1'b1;
        instr       = mk(8, 3, 0, 0);
        imm_data    = 16'h00AA;
        model_issue(8, 3, 0, 0, 16'h00AA);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("resp_no_latch", alu_a, 16'h1234);
            check("resp_instr_ready", instr_ready, 0);
        end
        take(0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("late_accept_a", alu_a, 16'h00AA);
        check("late_accept_opc", alu_opcode, 4'd6);
        collect(0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("single_accept", result_valid, 0);
        end
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing side of the ALU interface: accepts instruction words over a valid/ready handshake and reads two operands from an internal register file.
- Drives the combinational ALU (operands plus 4-bit opcode) and samples the ALU result and flags {overflow, negative, zero}.
- Writes the result back to the register file, keeps a sticky status-flag register, and returns the result over a second valid/ready handshake.
- Sits between the instruction source (testbench or fetch unit) and the ALU.

Parameters:
- BW, 16, datapath bitwidth; must match the ALU instance.
- NREG, 8, register-file depth; power of two, max 8 (3-bit register fields).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction word present
- instr_ready  output  1  sequencer can accept an instruction
- instr  input  16  {op[15:12], rd[11:9], ra[8:6], rb[5:3], unused[2:0]}
- imm_data  input  BW  immediate for LOAD, sampled with instr
- alu_a  output  BW  ALU operand A
- alu_b  output  BW  ALU operand B
- alu_opcode  output  4  ALU opcode
- alu_out  input  BW  ALU result (combinational from alu_a/alu_b/alu_opcode)
- alu_flags  input  3  ALU flags {overflow, negative, zero}
- result_valid  output  1  result available
- result_ready  input  1  consumer takes result
- result_data  output  BW  result value
- result_flags  output  3  flags associated with result
- status_flags  output  3  sticky flag register (last flag-updating instruction)

Behaviour:
- Reset (async, immediate):
  - State IDLE; all NREG registers = 0; status_flags = 0.
  - alu_a, alu_b, alu_opcode, result_data, result_flags = 0; result_valid = 0.
  - Reset mid-operation aborts the instruction: no writeback, result dropped.
- States: IDLE -> EXEC -> RESP -> IDLE. Throughput is one instruction per 3 cycles minimum.
- IDLE:
  - instr_ready = 1, all other handshake outputs 0.
  - On instr_valid && instr_ready, latch op and rd.
  - Register alu_a = RF[ra], alu_b = RF[rb], alu_opcode = op[3:0]. Go to EXEC.
- LOAD (op = 8) at accept: alu_a = imm_data, alu_b = 0, alu_opcode = 6 (pass A).
- NOP (op = 9..15) at accept: alu_a = alu_b = 0, alu_opcode = 0.
- EXEC (1 cycle; alu_* held stable): on the cycle's end, sample alu_out and alu_flags.
  - op 0..8: RF[rd] <= alu_out; status_flags <= alu_flags; result_flags <= alu_flags; result_data <= alu_out.
  - op 9..15: no RF write, status_flags unchanged; result_data <= 0; result_flags <= status_flags.
  - Go to RESP.
- RESP:
  - result_valid = 1; result_data and result_flags held stable until result_ready.
  - On result_ready, go to IDLE. result_valid deasserts the next cycle.
  - instr_ready = 0 in RESP, so no instruction is accepted in the same cycle the result is taken.
- Latency: instruction accepted at edge N -> RF written at edge N+1 -> result_valid high from N+1 to N+2 (visible the cycle after EXEC).
- Hazards:
  - The RF write completes before the next accept, so a dependent back-to-back instruction reads the new value.
  - ra == rb == rd is legal.
- Arithmetic: all modulo 2^BW. Flags come from the ALU; the sequencer never recomputes them.
- result_ready held high while no result is pending: ignored.
- instr_valid deasserted before acceptance: no effect (no accept outside IDLE).

Test Plan:
- Reset, then LOAD r1 = 0x7FFF and LOAD r2 = 0x0001, then ADD r3 = r1 + r2 -> result_data = 0x8000, result_flags = 3'b110, RF[3] = 0x8000, status_flags = 3'b110.
- LOAD r4 = 0x0005, then SUB r5 = r4 - r4 -> result_data = 0, result_flags = 3'b001; a following NOP returns result_data = 0, result_flags = 3'b001, status unchanged.
- Back-to-back INC r1 = r1 + 1 twice from r1 = 0xFFFE -> results 0xFFFF (flags 3'b010) then 0x0000 (flags 3'b001).
- Hold result_ready low for 5 cycles after result_valid -> result_data and result_flags stable, instr_ready stays 0; release -> IDLE the next cycle, instr_ready = 1.
- Assert rst during EXEC of ADD r6 = r1 + r2 -> immediately result_valid = 0 and state IDLE; RF[6] = 0, status_flags = 0.
- Drive instr_valid with instr_ready low (in RESP) -> instruction not latched; it is accepted only after return to IDLE, exactly once.
